adder_error_monitor: RTL and testbench
======================================

# adder_error_monitor

Streaming error-metric accumulator that sits directly downstream of the 16-bit adder pair (one exact carry-ripple adder, one approximate adder). Each cycle it consumes an exact and an approximate `{cout, Y}` result, computes the error distance and accumulates three metrics over a programmed number of samples: erroneous-result count, error-distance sum and maximum error distance. The approximate-adder evaluation flow reads these metrics once `done` is asserted.

## Interface
Parameters:
- `WIDTH`, 16: adder operand/result width; compared values are `WIDTH+1` bits including carry-out.
- `CNT_W`, 16: sample-counter and error-counter width.
- `ACC_W`, 32: error-distance sum width; must be ≥ `WIDTH+1`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  starts a run; sampled only in IDLE or DONE.
- `n_samples`  in  CNT_W  number of samples in the run; latched on `start`.
- `in_valid`  in  1  exact/approx result pair valid.
- `in_ready`  out  1  block accepts the pair this cycle.
- `Y_exact`, `cout_exact`  in  WIDTH, 1  exact adder result.
- `Y_appr`, `cout_appr`  in  WIDTH, 1  approximate adder result.
- `err_count`  out  CNT_W  number of accepted pairs with nonzero error.
- `sum_ed`  out  ACC_W  saturating sum of error distances.
- `max_ed`  out  WIDTH+1  largest error distance seen.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE; results are final.

## Operation
- ed = |{cout_exact,Y_exact} − {cout_appr,Y_appr}|, unsigned, `WIDTH+1` bits. A pair is erroneous when ed ≠ 0.
- FSM states are IDLE, RUN, DRAIN and DONE.
  - IDLE/DONE with `start`=1: latch `n_samples`, clear the sample counter and all three metrics, and clear the pipeline valid bit. If n=0, go to DONE; otherwise go to RUN.
  - RUN: `in_ready` = 1 while accepted < n. A pair is accepted when `in_valid & in_ready`. On the accept of sample n, go to DRAIN.
  - DRAIN: lasts one cycle, then go to DONE.
  - DONE: hold the results and `done`=1 until the next `start`.
- `start` is ignored in RUN and DRAIN. `in_valid` is ignored outside RUN, and pairs are not counted there.
- Arithmetic:
  - `sum_ed` saturates at 2^ACC_W−1 and never wraps.
  - `err_count` cannot overflow because it is bounded by n.
  - `max_ed` updates when ed > current `max_ed`.
- Reset: state IDLE; all outputs 0, including `in_ready`, `busy`, `done` and all metrics. Reset during RUN or DRAIN abandons the run; partial results are lost.

## Timing
- The block has two stages.
  - Stage 1: at the accept edge, register ed and the erroneous flag, and set the pipeline valid bit.
  - Stage 2: at the next edge, update the metrics.
- `in_ready` is a registered-state function (state, counter), with no combinational path from `in_valid`.
- Throughput is one pair per cycle.
- Last accept at edge k: state is DRAIN after k. Metrics are final and `done`=1 after edge k+1.
- For n=0, `done`=1 one edge after `start`.
- A `start` in DONE clears the metrics and `done` on the same edge.

## Structure
- Package `adder_eval_pkg` holds the state enum (`IDLE`, `RUN`, `DRAIN`, `DONE`) and the default `WIDTH`/`CNT_W`/`ACC_W` constants shared with the other evaluation blocks.
- Sub-module `adder_err_distance` is combinational. It takes two `WIDTH+1`-bit values and produces ed and the nonzero flag.
- The top level contains the FSM, counter, stage registers and accumulators.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `in_valid`=1 → all outputs 0, `in_ready`=0, state IDLE.
- **Exact match:** `start` with n=1; pair {0,FFFF}/{0,FFFF} → `done` one cycle after accept; `err_count`=0, `sum_ed`=0, `max_ed`=0.
- **Mixed run:** n=3; pairs are 0x1AA54/0x0AA54, 0x1A909/0x1A901 and 0x0FFFF/0x0FFFF → `err_count`=2, `sum_ed`=0x10008, `max_ed`=0x10000.
- **Handshake gaps:** n=4 with `in_valid` pattern 1,0,0,1,1,0,1, plus `in_valid` pulses while in IDLE → exactly 4 pairs counted. `in_ready` drops after the 4th accept. `busy` is high only in RUN and DRAIN.
- **Saturation:** `ACC_W`=17, n=2, both pairs with ed=0x10000 → `sum_ed`=0x1FFFF, `err_count`=2.
- **Corner cases:**
  - n=0 → `done` one cycle after `start`, all metrics 0.
  - `start` pulsed mid-RUN → ignored.
  - `rst_n`=0 mid-RUN → IDLE with all outputs 0; a following n=1 run gives correct results.

Source files
------------

// File: rtl/adder_eval_pkg.sv
// Shared types and default sizes for the approximate-adder evaluation blocks.
package adder_eval_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_ACC_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/adder_err_distance.sv
// Unsigned error distance |a - b| between two adder results, plus nonzero flag.
module adder_err_distance #(
    parameter int W = 17
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] ed_o,
    output logic         nz_o
);

    always_comb begin
        ed_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
        nz_o = (a_i != b_i);
    end

endmodule

// File: rtl/adder_error_monitor.sv
// Two-stage streaming accumulator of error count, saturating ED sum and max ED
// between an exact and an approximate adder result stream.
module adder_error_monitor
    import adder_eval_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Y_exact,
    input  logic             cout_exact,
    input  logic [WIDTH-1:0] Y_appr,
    input  logic             cout_appr,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [WIDTH:0]   max_ed,
    output logic             busy,
    output logic             done
);

    localparam int VW = WIDTH + 1;
    localparam int SW = ACC_W + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pv_q, pv_d;
    logic             perr_q, perr_d;
    logic [VW-1:0]    ped_q, ped_d;
    logic [CNT_W-1:0] errc_q, errc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [VW-1:0]    max_q, max_d;

    logic [VW-1:0] ed;
    logic          nz;
    logic [SW-1:0] sum_ext;
    logic          ready;
    logic          accept;
    logic          last;

    adder_err_distance #(.W(VW)) u_ed (
        .a_i  ({cout_exact, Y_exact}),
        .b_i  ({cout_appr, Y_appr}),
        .ed_o (ed),
        .nz_o (nz)
    );

    // Ready depends only on registered state, never on in_valid.
    assign ready   = (state_q == RUN) && (cnt_q < n_q);
    assign accept  = in_valid & ready;
    assign last    = ((cnt_q + CNT_W'(1)) == n_q);
    assign sum_ext = {1'b0, sum_q} + SW'(ped_q);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        pv_d    = accept;
        perr_d  = accept ? nz : perr_q;
        ped_d   = accept ? ed : ped_q;
        errc_d  = errc_q;
        sum_d   = sum_q;
        max_d   = max_q;

        if (pv_q) begin
            if (perr_q) begin
                errc_d = errc_q + CNT_W'(1);
            end
            sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            if (ped_q > max_q) begin
                max_d = ped_q;
            end
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    n_d     = n_samples;
                    cnt_d   = '0;
                    errc_d  = '0;
                    sum_d   = '0;
                    max_d   = '0;
                    pv_d    = 1'b0;
                    state_d = (n_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            pv_q    <= 1'b0;
            perr_q  <= 1'b0;
            ped_q   <= '0;
            errc_q  <= '0;
            sum_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            pv_q    <= pv_d;
            perr_q  <= perr_d;
            ped_q   <= ped_d;
            errc_q  <= errc_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
        end
    end

    assign in_ready  = ready;
    assign err_count = errc_q;
    assign sum_ed    = sum_q;
    assign max_ed    = max_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_adder_error_monitor.sv
// Directed bench: default instance plus an ACC_W=17 instance sharing stimulus.
module tb_adder_error_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] n_samples;
    logic        in_valid;
    logic [15:0] Y_exact, Y_appr;
    logic        cout_exact, cout_appr;

    logic        in_ready, busy, done;
    logic [15:0] err_count;
    logic [31:0] sum_ed;
    logic [16:0] max_ed;

    logic        in_ready_b, busy_b, done_b;
    logic [15:0] err_count_b;
    logic [16:0] sum_ed_b;
    logic [16:0] max_ed_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adder_error_monitor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready),
        .Y_exact(Y_exact), .cout_exact(cout_exact),
        .Y_appr(Y_appr), .cout_appr(cout_appr),
        .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed),
        .busy(busy), .done(done)
    );

    adder_error_monitor #(.ACC_W(17)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .Y_exact(Y_exact), .cout_exact(cout_exact),
        .Y_appr(Y_appr), .cout_appr(cout_appr),
        .err_count(err_count_b), .sum_ed(sum_ed_b), .max_ed(max_ed_b),
        .busy(busy_b), .done(done_b)
    );

    typedef struct {
        int               n;
        logic [3:0][16:0] ex;
        logic [3:0][16:0] ap;
        logic [15:0]      e_cnt;
        logic [31:0]      e_sum;
        logic [16:0]      e_max;
        logic [16:0]      e_sum17;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic pair(input logic [16:0] ex, input logic [16:0] ap);
        {cout_exact, Y_exact} = ex;
        {cout_appr, Y_appr}   = ap;
    endtask

    task automatic chk_zero(input string t);
        chk({t, ".rdy"},  64'(in_ready),    0);
        chk({t, ".busy"}, 64'(busy),        0);
        chk({t, ".done"}, 64'(done),        0);
        chk({t, ".cnt"},  64'(err_count),   0);
        chk({t, ".sum"},  64'(sum_ed),      0);
        chk({t, ".max"},  64'(max_ed),      0);
        chk({t, ".sumb"}, 64'(sum_ed_b),    0);
        chk({t, ".cntb"}, 64'(err_count_b), 0);
    endtask

    task automatic do_run(input string t, input vec_t v);
        start     = 1'b1;
        n_samples = 16'(v.n);
        step();
        start = 1'b0;
        if (v.n > 0) begin
            chk({t, ".busy0"}, 64'(busy), 1);
            chk({t, ".done0"}, 64'(done), 0);
            for (int i = 0; i < v.n; i++) begin
                in_valid = 1'b1;
                pair(v.ex[i], v.ap[i]);
                step();
            end
            in_valid = 1'b0;
            chk({t, ".drain_rdy"},  64'(in_ready), 0);
            chk({t, ".drain_busy"}, 64'(busy),     1);
            chk({t, ".drain_done"}, 64'(done),     0);
            step();
        end
        chk({t, ".done"}, 64'(done),        1);
        chk({t, ".busy"}, 64'(busy),        0);
        chk({t, ".cnt"},  64'(err_count),   64'(v.e_cnt));
        chk({t, ".sum"},  64'(sum_ed),      64'(v.e_sum));
        chk({t, ".max"},  64'(max_ed),      64'(v.e_max));
        chk({t, ".sumb"}, 64'(sum_ed_b),    64'(v.e_sum17));
        chk({t, ".cntb"}, 64'(err_count_b), 64'(v.e_cnt));
    endtask

    initial begin
        tbl[0] = '{1, {4{17'h0}} | {51'h0, 17'h0FFFF}, {51'h0, 17'h0FFFF},
                   16'd0, 32'h0, 17'h0, 17'h0};
        tbl[1] = '{3, {17'h0, 17'h0FFFF, 17'h1A909, 17'h1AA54},
                   {17'h0, 17'h0FFFF, 17'h1A901, 17'h0AA54},
                   16'd2, 32'h10008, 17'h10000, 17'h10008};
        tbl[2] = '{1, {51'h0, 17'h00000}, {51'h0, 17'h1FFFF},
                   16'd1, 32'h1FFFF, 17'h1FFFF, 17'h1FFFF};
        tbl[3] = '{2, {34'h0, 17'h10000, 17'h00010},
                   {34'h0, 17'h0FFFF, 17'h00013},
                   16'd2, 32'h4, 17'h3, 17'h4};
        tbl[4] = '{2, {34'h0, 17'h10000, 17'h10000},
                   {34'h0, 17'h00000, 17'h00000},
                   16'd2, 32'h20000, 17'h10000, 17'h1FFFF};
        tbl[5] = '{0, '0, '0, 16'd0, 32'h0, 17'h0, 17'h0};

        rst_n = 1'b0; start = 1'b0; n_samples = '0;
        in_valid = 1'b1;
        pair(17'h1FFFF, 17'h0);
        step();
        step();
        chk_zero("reset");

        // Pairs offered while idle must not be counted.
        rst_n = 1'b1;
        step();
        step();
        chk("idle.rdy", 64'(in_ready), 0);
        chk("idle.busy", 64'(busy), 0);
        in_valid = 1'b0;

        // Handshake gaps: accepts at i=0,3,4,6 give ed 0,3,4,6.
        start = 1'b1; n_samples = 16'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i == 0 || i == 3 || i == 4 || i == 6);
            pair(17'h100 + 17'(i), 17'h100);
            chk($sformatf("gap.rdy%0d", i), 64'(in_ready), 1);
            chk($sformatf("gap.busy%0d", i), 64'(busy), 1);
            step();
        end
        chk("gap.rdy_after", 64'(in_ready), 0);
        chk("gap.busy_drain", 64'(busy), 1);
        in_valid = 1'b1;
        step();
        chk("gap.done", 64'(done), 1);
        chk("gap.busy_done", 64'(busy), 0);
        chk("gap.cnt", 64'(err_count), 3);
        chk("gap.sum", 64'(sum_ed), 13);
        chk("gap.max", 64'(max_ed), 6);
        step();
        in_valid = 1'b0;
        chk("gap.hold_cnt", 64'(err_count), 3);
        chk("gap.hold_sum", 64'(sum_ed), 13);

        for (int r = 0; r < 6; r++) begin
            do_run($sformatf("row%0d", r), tbl[r]);
        end

        // Start from DONE clears metrics and done on the same edge.
        do_run("prep", tbl[2]);
        start = 1'b1; n_samples = 16'd2;
        step();
        start = 1'b0;
        chk("restart.done", 64'(done), 0);
        chk("restart.cnt", 64'(err_count), 0);
        chk("restart.sum", 64'(sum_ed), 0);
        chk("restart.max", 64'(max_ed), 0);

        // Start pulsed mid-run is ignored.
        in_valid = 1'b1;
        pair(17'h5, 17'h1);
        step();
        in_valid = 1'b0;
        start = 1'b1; n_samples = 16'd5;
        step();
        start = 1'b0;
        chk("midstart.busy", 64'(busy), 1);
        chk("midstart.rdy", 64'(in_ready), 1);
        in_valid = 1'b1;
        pair(17'h1, 17'h7);
        step();
        in_valid = 1'b0;
        chk("midstart.drain_rdy", 64'(in_ready), 0);
        step();
        chk("midstart.done", 64'(done), 1);
        chk("midstart.cnt", 64'(err_count), 2);
        chk("midstart.sum", 64'(sum_ed), 10);
        chk("midstart.max", 64'(max_ed), 6);

        // Reset mid-run abandons the run.
        start = 1'b1; n_samples = 16'd3;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        pair(17'h9, 17'h1);
        step();
        step();
        rst_n = 1'b0;
        step();
        in_valid = 1'b0;
        chk_zero("midreset");
        rst_n = 1'b1;
        step();
        do_run("postreset", tbl[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
